// File: rtl/draw_sched.sv
// draw_sched: per-frame display-list walker. Reads entries from a synchronous
// list ROM, decodes END / WAIT_FRAME locally and forwards every other opcode
// to the drawing engine over a valid/ready handshake.
module draw_sched #(
  parameter  int CORDW      = 16,
  parameter  int CIDXW      = 4,
  parameter  int LIST_ADDRW = 8,
  parameter  int LIST_LEN   = 256,
  localparam int ENTRY_W    = 8 + 4*CORDW
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys,
  input  logic                    frame,
  input  logic                    enable,
  output logic                    list_rd,
  output logic [LIST_ADDRW-1:0]   list_addr,
  input  logic [ENTRY_W-1:0]      list_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [3:0]              cmd_op,
  output logic [CIDXW-1:0]        cmd_colr,
  output logic signed [CORDW-1:0] cmd_x0,
  output logic signed [CORDW-1:0] cmd_y0,
  output logic signed [CORDW-1:0] cmd_x1,
  output logic signed [CORDW-1:0] cmd_y1,
  input  logic                    eng_busy,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam logic [3:0]            OP_END    = 4'h0;
  localparam logic [3:0]            OP_WAIT   = 4'hF;
  localparam logic [LIST_ADDRW-1:0] LAST_ADDR = LIST_ADDRW'(LIST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAITF,
    DRAIN
  } state_t;

  state_t                  state_reg, state_next;
  logic [LIST_ADDRW-1:0]   addr_reg, addr_next;
  logic                    overrun_reg, overrun_next;
  logic                    done_next;
  logic [3:0]              op_reg;
  logic [CIDXW-1:0]        colr_reg;
  logic signed [CORDW-1:0] x0_reg, y0_reg, x1_reg, y1_reg;

  logic [3:0] entry_op;
  logic       at_last;

  assign entry_op = list_data[3:0];
  assign at_last  = (addr_reg == LAST_ADDR);

  // Next-state, next-address and the frame-collision pulse.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    done_next    = 1'b0;
    overrun_next = frame && (state_reg == FETCH || state_reg == LOAD ||
                             state_reg == ISSUE || state_reg == DRAIN);
    case (state_reg)
      IDLE: begin
        // enable only matters here; a list already running always completes
        if (frame && enable) begin
          state_next = FETCH;
          addr_next  = '0;
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        if (entry_op == OP_END || (at_last && entry_op == OP_WAIT)) begin
          state_next = DRAIN;
        end else if (entry_op == OP_WAIT) begin
          state_next = WAITF;
        end else begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          // the last slot ends the list implicitly; the address never wraps
          if (at_last) begin
            state_next = DRAIN;
          end else begin
            state_next = FETCH;
            addr_next  = addr_reg + 1'b1;
          end
        end
      end
      WAITF: begin
        if (frame) begin
          if (at_last) begin
            state_next = DRAIN;
          end else begin
            state_next = FETCH;
            addr_next  = addr_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!eng_busy) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state, list pointer and overrun flag.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      overrun_reg <= overrun_next;
    end
  end

  // Command fields: captured from the entry in LOAD, held through ISSUE.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      op_reg   <= '0;
      colr_reg <= '0;
      x0_reg   <= '0;
      y0_reg   <= '0;
      x1_reg   <= '0;
      y1_reg   <= '0;
    end else if (state_reg == LOAD) begin
      op_reg   <= list_data[3:0];
      colr_reg <= list_data[4 +: CIDXW];
      x0_reg   <= list_data[8 +: CORDW];
      y0_reg   <= list_data[8 + CORDW +: CORDW];
      x1_reg   <= list_data[8 + 2*CORDW +: CORDW];
      y1_reg   <= list_data[8 + 3*CORDW +: CORDW];
    end
  end

  assign list_rd   = (state_reg == FETCH);
  assign list_addr = addr_reg;
  assign cmd_valid = (state_reg == ISSUE);
  assign busy      = (state_reg != IDLE);
  // done must coincide with the first idle-engine cycle seen in DRAIN
  assign done      = done_next;
  assign overrun   = overrun_reg;
  assign cmd_op    = op_reg;
  assign cmd_colr  = colr_reg;
  assign cmd_x0    = x0_reg;
  assign cmd_y0    = y0_reg;
  assign cmd_x1    = x1_reg;
  assign cmd_y1    = y1_reg;

endmodule

// File: tb/tb_draw_sched.sv
// Bench for draw_sched: directed scenarios plus randomized lists, checked
// against a list-walking reference model and a handshake scoreboard.
module tb_draw_sched;

  localparam int CW  = 16;
  localparam int AW  = 2;
  localparam int LEN = 4;
  localparam int EW  = 8 + 4*CW;

  logic          clk_sys = 1'b0;
  logic          rst_sys = 1'b1;
  logic          frame = 1'b0;
  logic          enable = 1'b0;
  logic          list_rd;
  logic [AW-1:0] list_addr;
  logic [EW-1:0] list_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b1;
  logic [3:0]    cmd_op;
  logic [3:0]    cmd_colr;
  logic signed [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic          eng_busy = 1'b0;
  logic          busy, done, overrun;

  int n_checks = 0;
  int n_fail = 0;

  logic [EW-1:0] rom [LEN];
  logic [71:0]   exp_cmds[$], obs_cmds[$];
  int            exp_reads[$], obs_reads[$];
  int            done_cnt, ovr_cnt;

  draw_sched #(
    .CORDW(CW), .CIDXW(4), .LIST_ADDRW(AW), .LIST_LEN(LEN)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .frame(frame), .enable(enable),
    .list_rd(list_rd), .list_addr(list_addr), .list_data(list_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_colr(cmd_colr), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1),
    .cmd_y1(cmd_y1), .eng_busy(eng_busy), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous list ROM: data valid the cycle after list_rd.
  always @(posedge clk_sys) begin
    if (rst_sys) list_data <= '0;
    else if (list_rd) list_data <= rom[list_addr];
  end

  // Monitor on the falling edge: handshakes, reads and pulses.
  always @(negedge clk_sys) begin
    if (!rst_sys) begin
      if (cmd_valid && cmd_ready)
        obs_cmds.push_back({cmd_op, cmd_colr, cmd_x0, cmd_y0, cmd_x1, cmd_y1});
      if (list_rd) obs_reads.push_back(int'(list_addr));
      if (done) done_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check_value(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [EW-1:0] mk(input logic [3:0] op, input logic [3:0] c,
      input logic signed [CW-1:0] x0, input logic signed [CW-1:0] y0,
      input logic signed [CW-1:0] x1, input logic signed [CW-1:0] y1);
    return {y1, x1, y0, x0, c, op};
  endfunction

  // Reference: walk the list from entry 0 following the opcode rules.
  task automatic build_expect();
    int i;
    logic [EW-1:0] e;
    exp_cmds.delete();
    exp_reads.delete();
    i = 0;
    forever begin
      exp_reads.push_back(i);
      e = rom[i];
      if (e[3:0] == 4'h0) break;
      if (e[3:0] != 4'hF)
        exp_cmds.push_back({e[3:0], e[7:4], e[8 +: CW], e[8+CW +: CW],
                            e[8+2*CW +: CW], e[8+3*CW +: CW]});
      if (i == LEN - 1) break;
      i++;
    end
  endtask

  task automatic clear_obs();
    obs_cmds.delete();
    obs_reads.delete();
    done_cnt = 0;
    ovr_cnt = 0;
  endtask

  task automatic finish_run(input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc();
      n++;
      if (done_cnt != 0) break;
      if (rnd) begin
        cmd_ready = ($urandom_range(0, 3) != 0);
        eng_busy  = ($urandom_range(0, 1) != 0);
        enable    = ($urandom_range(0, 1) != 0);
        frame     = ($urandom_range(0, 15) == 0);
      end
    end
    frame = 1'b0;
    cmd_ready = 1'b1;
    eng_busy = 1'b0;
    enable = 1'b1;
    check_value("run_timeout", 80'(done_cnt != 0), 80'd1);
    if (done_cnt == 0) begin
      rst_sys = 1'b1;
      cyc();
      rst_sys = 1'b0;
    end
  endtask

  task automatic compare_run(input string name, input int exp_ovr);
    check_value({name, "_ncmds"}, 80'(obs_cmds.size()), 80'(exp_cmds.size()));
    for (int k = 0; k < exp_cmds.size() && k < obs_cmds.size(); k++)
      check_value({name, "_cmd"}, 80'(obs_cmds[k]), 80'(exp_cmds[k]));
    check_value({name, "_nreads"}, 80'(obs_reads.size()), 80'(exp_reads.size()));
    for (int k = 0; k < exp_reads.size() && k < obs_reads.size(); k++)
      check_value({name, "_raddr"}, 80'(obs_reads[k]), 80'(exp_reads[k]));
    check_value({name, "_done"}, 80'(done_cnt), 80'd1);
    check_value({name, "_overrun"}, 80'(ovr_cnt), 80'(exp_ovr));
    cyc();
    check_value({name, "_busy_after"}, 80'(busy), 80'd0);
    $display("run %s: cmds=%0d reads=%0d done=%0d overrun=%0d", name,
             obs_cmds.size(), obs_reads.size(), done_cnt, ovr_cnt);
  endtask

  task automatic start_frame();
    cyc();
    frame = 1'b1;
    enable = 1'b1;
    cyc();
    frame = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < LEN; k++) rom[k] = '0;
    clear_obs();
    repeat (3) cyc();
    // reset values
    check_value("rst_list_rd", 80'(list_rd), 80'd0);
    check_value("rst_cmd_valid", 80'(cmd_valid), 80'd0);
    check_value("rst_busy", 80'(busy), 80'd0);
    check_value("rst_done", 80'(done), 80'd0);
    check_value("rst_overrun", 80'(overrun), 80'd0);
    check_value("rst_addr", 80'(list_addr), 80'd0);
    check_value("rst_fields", 80'({cmd_op, cmd_colr, cmd_x0, cmd_y0, cmd_x1, cmd_y1}), 80'd0);
    rst_sys = 1'b0;

    // single line then END: cycle-exact timing
    rom[0] = mk(4'h1, 4'h5, 1, 2, 3, 4);
    rom[1] = '0; rom[2] = '0; rom[3] = '0;
    build_expect();
    clear_obs();
    cyc();                        // T
    check_value("t0_busy", 80'(busy), 80'd0);
    frame = 1'b1; enable = 1'b1;
    cyc(); frame = 1'b0;          // T+1
    check_value("t1_list_rd", 80'(list_rd), 80'd1);
    check_value("t1_addr", 80'(list_addr), 80'd0);
    cyc();                        // T+2
    check_value("t2_valid", 80'(cmd_valid), 80'd0);
    cyc();                        // T+3
    check_value("t3_valid", 80'(cmd_valid), 80'd1);
    check_value("t3_op", 80'(cmd_op), 80'd1);
    check_value("t3_colr", 80'(cmd_colr), 80'd5);
    check_value("t3_coords", 80'({cmd_x0, cmd_y0, cmd_x1, cmd_y1}),
                80'({16'sd1, 16'sd2, 16'sd3, 16'sd4}));
    cyc();                        // T+4
    check_value("t4_list_rd", 80'(list_rd), 80'd1);
    check_value("t4_addr", 80'(list_addr), 80'd1);
    check_value("t4_valid", 80'(cmd_valid), 80'd0);
    cyc();                        // T+5
    cyc();                        // T+6
    check_value("t6_done", 80'(done), 80'd1);
    check_value("t6_busy", 80'(busy), 80'd1);
    cyc();                        // T+7
    check_value("t7_busy", 80'(busy), 80'd0);
    check_value("t7_done", 80'(done), 80'd0);
    compare_run("basic", 0);

    // back-pressure: ready low for five ISSUE cycles
    clear_obs();
    cmd_ready = 1'b0;
    start_frame();
    cyc(); cyc();                 // T+3
    for (int k = 0; k < 5; k++) begin
      check_value("stall_valid", 80'(cmd_valid), 80'd1);
      check_value("stall_fields", 80'({cmd_op, cmd_colr, cmd_x0, cmd_y0, cmd_x1, cmd_y1}),
                  80'(exp_cmds[0]));
      check_value("stall_reads", 80'(obs_reads.size()), 80'd1);
      if (k == 4) cmd_ready = 1'b1;
      else cyc();
    end
    finish_run(50, 1'b0);
    compare_run("stall", 0);

    // WAIT_FRAME holds the list until the next frame pulse
    rom[0] = mk(4'h2, 4'h3, 10, 20, 30, 40);
    rom[1] = mk(4'hF, 4'h0, 0, 0, 0, 0);
    rom[2] = mk(4'h2, 4'h7, -5, -6, 100, 200);
    rom[3] = '0;
    build_expect();
    clear_obs();
    start_frame();
    repeat (20) cyc();
    check_value("waitf_reads", 80'(obs_reads.size()), 80'd2);
    check_value("waitf_busy", 80'(busy), 80'd1);
    frame = 1'b1;
    cyc(); frame = 1'b0;
    finish_run(50, 1'b0);
    compare_run("waitframe", 0);

    // frame in ISSUE and in DRAIN (engine busy) -> two overruns, one done
    rom[0] = mk(4'h1, 4'h5, 1, 2, 3, 4);
    rom[1] = '0; rom[2] = '0;
    build_expect();
    clear_obs();
    cmd_ready = 1'b0; eng_busy = 1'b1;
    start_frame();                // T+1
    cyc(); cyc();                 // T+3, ISSUE
    frame = 1'b1;
    cyc(); frame = 1'b0; cmd_ready = 1'b1;   // T+4
    cyc(); cyc(); cyc();          // T+7, DRAIN
    frame = 1'b1;
    cyc(); frame = 1'b0;
    repeat (5) cyc();
    check_value("ovr_no_early_done", 80'(done_cnt), 80'd0);
    eng_busy = 1'b0;
    finish_run(50, 1'b0);
    compare_run("overrun", 2);

    // full list with no END entry: implicit end, no wrap
    for (int k = 0; k < LEN; k++) rom[k] = mk(4'h1, 4'(k), CW'(k), CW'(k+1), CW'(-k), 7);
    build_expect();
    clear_obs();
    eng_busy = 1'b1;
    start_frame();
    repeat (20) cyc();
    check_value("noend_busy_hold", 80'(done_cnt), 80'd0);
    eng_busy = 1'b0;
    finish_run(50, 1'b0);
    compare_run("noend", 0);

    // disabled frame, then reset mid-ISSUE, then clean restart
    rom[0] = mk(4'h3, 4'h9, 11, 12, 13, 14);
    rom[1] = '0;
    build_expect();
    clear_obs();
    cyc(); enable = 1'b0; frame = 1'b1;
    cyc(); frame = 1'b0;
    repeat (10) cyc();
    check_value("dis_reads", 80'(obs_reads.size()), 80'd0);
    check_value("dis_busy", 80'(busy), 80'd0);
    cmd_ready = 1'b0;
    start_frame();
    cyc(); cyc();                 // ISSUE
    check_value("pre_rst_valid", 80'(cmd_valid), 80'd1);
    rst_sys = 1'b1;
    cyc();
    check_value("mid_rst_valid", 80'(cmd_valid), 80'd0);
    check_value("mid_rst_busy", 80'(busy), 80'd0);
    check_value("mid_rst_addr", 80'(list_addr), 80'd0);
    check_value("mid_rst_op", 80'(cmd_op), 80'd0);
    rst_sys = 1'b0; cmd_ready = 1'b1;
    clear_obs();
    start_frame();
    finish_run(50, 1'b0);
    compare_run("restart", 0);

    // randomized lists, handshake pressure and frame noise
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < LEN; k++) begin
        int sel;
        logic [3:0] op;
        sel = $urandom_range(0, 9);
        op = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(1, 14));
        rom[k] = mk(op, 4'($urandom), CW'($urandom), CW'($urandom),
                    CW'($urandom), CW'($urandom));
      end
      build_expect();
      clear_obs();
      start_frame();
      finish_run(3000, 1'b1);
      compare_run("random", ovr_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
